// File: rtl/serial_eq_comparator.sv
// serial_eq_comparator: bit-serial equality compare (LSB first) through one XNOR cell, reporting eq and the lowest differing bit
module serial_eq_comparator #(
  parameter int WIDTH = 4,
  parameter bit EARLY_EXIT = 1'b0,
  localparam int IDXW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDXW-1:0]  mismatch_idx
);
  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_sa, r_sb;
  logic [IDXW-1:0]  r_cnt, r_first_idx, r_idx;
  logic             r_acc, r_ready, r_busy, r_done, r_eq;
  logic             w_bit_eq, w_last, w_exit;
  assign w_bit_eq = r_sa[0] ~^ r_sb[0];
  assign w_last = r_cnt == IDXW'(WIDTH - 1);
  assign w_exit = w_last | (EARLY_EXIT & ~w_bit_eq);
  assign ready = r_ready;
  assign busy = r_busy;
  assign done = r_done;
  assign eq = r_eq;
  assign mismatch_idx = r_idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa <= '0;
      r_sb <= '0;
      r_cnt <= '0;
      r_first_idx <= '0;
      r_acc <= 1'b0;
      r_ready <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_eq <= 1'b0;
      r_idx <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_COMPARE;
          r_sa <= a;
          r_sb <= b;
          r_cnt <= '0;
          r_acc <= 1'b1;
          r_first_idx <= '0;
          r_ready <= 1'b0;
          r_busy <= 1'b1;
        end
        S_COMPARE: begin
          if (!w_bit_eq && r_acc) begin
            r_first_idx <= r_cnt;
            r_acc <= 1'b0;
          end
          r_sa <= r_sa >> 1;
          r_sb <= r_sb >> 1;
          r_cnt <= r_cnt + 1'b1;
          // the final bit's verdict is folded in here since r_acc/r_first_idx update on the same edge
          if (w_exit) begin
            r_state <= S_DONE;
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_eq <= r_acc & w_bit_eq;
            r_idx <= (r_acc && !w_bit_eq) ? r_cnt : r_first_idx;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_eq_comparator.sv
// tb_serial_eq_comparator: full-scan and early-exit instances driven together, checked every cycle against a timing/result model
module tb_serial_eq_comparator;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic rdy[2], bsy[2], dn[2], eqo[2];
  logic [1:0] idx[2];
  int checks = 0, errors = 0;
  int ecount = 0;
  int e0[2] = '{-100, -100};
  int de[2] = '{-100, -100};
  int peq[2] = '{0, 0};
  int ceq[2] = '{0, 0};
  int pidx[2] = '{0, 0};
  int cidx[2] = '{0, 0};
  bit mr[2];
  always #5 clk = ~clk;
  serial_eq_comparator #(.WIDTH(W), .EARLY_EXIT(1'b0)) u_full (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .eq(eqo[0]), .mismatch_idx(idx[0]));
  serial_eq_comparator #(.WIDTH(W), .EARLY_EXIT(1'b1)) u_early (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .eq(eqo[1]), .mismatch_idx(idx[1]));
  function automatic int low(input logic [W-1:0] x);
    for (int i = 0; i < W; i++) if (x[i]) return i;
    return 0;
  endfunction
  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask
  // model: an op accepted at edge e0 is busy until its done edge de, then idle
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) mr[k] = !(ecount >= e0[k] && ecount <= de[k]);
    ecount++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e0[k] = -100; de[k] = -100; ceq[k] = 0; cidx[k] = 0;
      end else begin
        if (ecount == de[k]) begin ceq[k] = peq[k]; cidx[k] = pidx[k]; end
        if (mr[k] && start) begin
          peq[k] = int'(a == b);
          pidx[k] = low(a ^ b);
          e0[k] = ecount;
          de[k] = ecount + ((k == 1 && a != b) ? pidx[k] + 1 : W);
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (!rst) for (int k = 0; k < 2; k++) begin
      chk($sformatf("m_ready%0d", k), int'(rdy[k]), int'(!(ecount >= e0[k] && ecount <= de[k])));
      chk($sformatf("m_busy%0d", k), int'(bsy[k]), int'(ecount >= e0[k] && ecount < de[k]));
      chk($sformatf("m_done%0d", k), int'(dn[k]), int'(ecount == de[k]));
      chk($sformatf("m_eq%0d", k), int'(eqo[k]), ceq[k]);
      chk($sformatf("m_idx%0d", k), int'(idx[k]), cidx[k]);
    end
  end
  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y);
    #1 start = 1'b1; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask
  initial begin
    int n, mask;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(rdy[0]), 1);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_eq", int'(eqo[0]), 0);
    chk("rst_idx", int'(idx[0]), 0);
    repeat (10) @(negedge clk);
    chk("idle_ready", int'(rdy[0]), 1);
    go(4'b1011, 4'b1011);
    chk("eq_busy_c1", int'(bsy[0]), 1);
    chk("eq_ready_c1", int'(rdy[0]), 0);
    #1 start = 1'b1; a = 4'b0000; b = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("eq_done_c5", int'(dn[0]), 1);
    chk("eq_eq", int'(eqo[0]), 1);
    chk("eq_idx", int'(idx[0]), 0);
    chk("eq_early_done_c5", int'(dn[1]), 1);
    @(negedge clk);
    chk("eq_ready_c6", int'(rdy[0]), 1);
    chk("eq_done_c6", int'(dn[0]), 0);
    go(4'b1010, 4'b0010);
    repeat (4) @(negedge clk);
    chk("b3_done", int'(dn[0]), 1);
    chk("b3_eq", int'(eqo[0]), 0);
    chk("b3_idx", int'(idx[0]), 3);
    chk("b3_early_done", int'(dn[1]), 1);
    chk("b3_early_idx", int'(idx[1]), 3);
    @(negedge clk);
    go(4'b0110, 4'b0000);
    repeat (2) @(negedge clk);
    chk("b12_early_done_c3", int'(dn[1]), 1);
    chk("b12_early_idx", int'(idx[1]), 1);
    chk("b12_early_eq", int'(eqo[1]), 0);
    repeat (2) @(negedge clk);
    chk("b12_done_c5", int'(dn[0]), 1);
    chk("b12_idx", int'(idx[0]), 1);
    @(negedge clk);
    go(4'b0100, 4'b0000);
    repeat (3) @(negedge clk);
    chk("b2_early_done_c4", int'(dn[1]), 1);
    chk("b2_early_idx", int'(idx[1]), 2);
    chk("b2_full_done_c4", int'(dn[0]), 0);
    @(negedge clk);
    chk("b2_full_done_c5", int'(dn[0]), 1);
    chk("b2_full_idx", int'(idx[0]), 2);
    @(negedge clk);
    n = 0; mask = 0;
    #1 start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (dn[0]) begin n++; mask |= 1 << i; end
      a = 4'($urandom); b = 4'($urandom);
    end
    start = 1'b0;
    chk("held_done_count", n, 3);
    chk("held_done_cycles", mask, (1 << 5) | (1 << 11) | (1 << 17));
    repeat (10) @(negedge clk);
    go(4'b0011, 4'b0001);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    repeat (8) begin @(negedge clk); if (dn[0] || dn[1]) n++; end
    chk("abort_no_done", n, 0);
    chk("abort_ready", int'(rdy[0]), 1);
    chk("abort_eq", int'(eqo[0]), 0);
    chk("abort_idx", int'(idx[0]), 0);
    go(4'b1111, 4'b1111);
    repeat (4) @(negedge clk);
    chk("post_abort_done", int'(dn[0]), 1);
    chk("post_abort_eq", int'(eqo[0]), 1);
    @(negedge clk);
    repeat (400) begin
      @(negedge clk);
      #1 start = $urandom_range(0, 2) != 0;
      a = 4'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 4'($urandom);
      rst = $urandom_range(0, 150) == 0;
    end
    @(negedge clk);
    #1 rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
